// File: rtl/stack_pkg.sv
// +-------------------------------------------------------------------+
// | stack_pkg : shared types and opcodes for stack and stack_sequencer |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

package stack_pkg;

   typedef enum logic [2:0] {
      CMD_PEEK = 3'd0,
      CMD_PUSH = 3'd1,
      CMD_POP  = 3'd2,
      CMD_ADD  = 3'd3,
      CMD_MUL  = 3'd4
   } cmd_op_e;

   typedef enum logic [2:0] {
      RSP_OK        = 3'd0,
      RSP_UNDERFLOW = 3'd1,
      RSP_FULL      = 3'd2,
      RSP_OVERFLOW  = 3'd3,
      RSP_ILLEGAL   = 3'd4
   } rsp_status_e;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_PUSH = 3'b110;
   localparam logic [2:0] OP_POP  = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_EXEC_PUSH = 3'd1,
      ST_EXEC_POP  = 3'd2,
      ST_CALC      = 3'd3,
      ST_POP_A     = 3'd4,
      ST_POP_B     = 3'd5,
      ST_PUSH_R    = 3'd6,
      ST_RESP      = 3'd7
   } state_e;

endpackage

`default_nettype wire

// File: rtl/stack_sequencer_if.sv
// +-------------------------------------------------------------------+
// | stack_sequencer_if : command / response / depth bundle             |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

interface stack_sequencer_if #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 32
);
   localparam int DW = $clog2(DEPTH) + 1;

   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic [2:0]       rsp_status;
   logic [DW-1:0]    depth;

   modport master (
      output cmd_valid, cmd_op, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_status, depth
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_status, depth
   );
endinterface

`default_nettype wire

// File: rtl/stack.sv
// +-------------------------------------------------------------------+
// | stack : LIFO datapath with single-cycle push/pop/add/mul opcodes   |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module stack
   import stack_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] input_data,
   output logic [WIDTH-1:0] output_data,
   output logic             overflow,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [WIDTH-1:0]   mem_d [DEPTH];
   logic [CW-1:0]      count_q, count_d;
   logic [AW-1:0]      w_top_idx, w_sec_idx, w_push_idx;
   logic [WIDTH-1:0]   w_top, w_sec, w_sum;
   logic [2*WIDTH-1:0] w_prod;
   logic               w_add_ovf, w_mul_ovf;

   assign empty      = (count_q == '0);
   assign full       = (count_q == CW'(DEPTH));
   assign w_top_idx  = AW'(count_q - CW'(1));
   assign w_sec_idx  = AW'(count_q - CW'(2));
   assign w_push_idx = AW'(count_q);
   assign w_top      = empty ? '0 : mem_q[w_top_idx];
   assign w_sec      = mem_q[w_sec_idx];

   // Arithmetic is second-from-top (op) top; signed overflow is detected on the full result
   assign w_sum     = w_sec + w_top;
   assign w_add_ovf = (w_sec[WIDTH-1] == w_top[WIDTH-1]) && (w_sum[WIDTH-1] != w_sec[WIDTH-1]);
   assign w_prod    = {{WIDTH{w_sec[WIDTH-1]}}, w_sec} * {{WIDTH{w_top[WIDTH-1]}}, w_top};
   assign w_mul_ovf = (w_prod != {{WIDTH{w_prod[WIDTH-1]}}, w_prod[WIDTH-1:0]});

   always_comb begin
      output_data = w_top;
      overflow    = 1'b0;
      case (opcode)
         OP_ADD: begin
            output_data = w_sum;
            overflow    = w_add_ovf;
         end
         OP_MUL: begin
            output_data = w_prod[WIDTH-1:0];
            overflow    = w_mul_ovf;
         end
         default: ;
      endcase
   end

   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      case (opcode)
         OP_PUSH: if (!full) begin
            mem_d[w_push_idx] = input_data;
            count_d           = count_q + CW'(1);
         end
         OP_POP: if (!empty) count_d = count_q - CW'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
      mem_q <= mem_d;
   end

endmodule

`default_nettype wire

// File: rtl/stack_sequencer.sv
// +-------------------------------------------------------------------+
// | stack_sequencer : command-level controller sequencing stack opcodes|
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module stack_sequencer
   import stack_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   stack_sequencer_if.slave    bus
);
   localparam int            CW          = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] C_DEPTH_MAX = CW'(DEPTH);

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   rsp_status_e      status_q, status_d;
   logic [CW-1:0]    depth_q, depth_d;

   logic [2:0]       stack_op;
   logic [WIDTH-1:0] stack_in, stack_out;
   logic             stack_ovf, stack_empty, stack_full;
   logic             cmd_ready, rsp_valid;
   logic             w_has1, w_has2, w_at_max;

   stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_stack (
      .clk         (clk),
      .rst_n       (~rst),
      .opcode      (stack_op),
      .input_data  (stack_in),
      .output_data (stack_out),
      .overflow    (stack_ovf),
      .empty       (stack_empty),
      .full        (stack_full)
   );

   assign w_has1   = (depth_q != '0);
   assign w_has2   = (depth_q >= CW'(2));
   assign w_at_max = (depth_q == C_DEPTH_MAX);

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      data_d    = data_q;
      status_d  = status_q;
      depth_d   = depth_q;
      stack_op  = OP_NOP;
      stack_in  = data_q;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               op_d     = bus.cmd_op;
               data_d   = '0;
               status_d = RSP_OK;
               state_d  = ST_RESP;
               // Precondition failures go straight to RESP without issuing any opcode
               case (bus.cmd_op)
                  CMD_PEEK: if (w_has1) data_d = stack_out;
                            else        status_d = RSP_UNDERFLOW;
                  CMD_PUSH: if (!w_at_max) begin
                               data_d  = bus.cmd_data;
                               state_d = ST_EXEC_PUSH;
                            end else status_d = RSP_FULL;
                  CMD_POP:  if (w_has1) state_d = ST_EXEC_POP;
                            else        status_d = RSP_UNDERFLOW;
                  CMD_ADD, CMD_MUL:
                            if (w_has2) state_d = ST_CALC;
                            else        status_d = RSP_UNDERFLOW;
                  default:  status_d = RSP_ILLEGAL;
               endcase
            end
         end
         ST_EXEC_PUSH: begin
            stack_op = OP_PUSH;
            depth_d  = depth_q + CW'(1);
            state_d  = ST_RESP;
         end
         ST_EXEC_POP: begin
            stack_op = OP_POP;
            data_d   = stack_out;
            depth_d  = depth_q - CW'(1);
            state_d  = ST_RESP;
         end
         ST_CALC: begin
            stack_op = (op_q == CMD_MUL) ? OP_MUL : OP_ADD;
            data_d   = stack_out;
            status_d = stack_ovf ? RSP_OVERFLOW : RSP_OK;
            state_d  = ST_POP_A;
         end
         ST_POP_A: begin
            stack_op = OP_POP;
            depth_d  = depth_q - CW'(1);
            state_d  = ST_POP_B;
         end
         ST_POP_B: begin
            stack_op = OP_POP;
            depth_d  = depth_q - CW'(1);
            state_d  = ST_PUSH_R;
         end
         ST_PUSH_R: begin
            stack_op = OP_PUSH;
            depth_d  = depth_q + CW'(1);
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (bus.rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         data_q   <= '0;
         status_q <= RSP_OK;
         depth_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         data_q   <= data_d;
         status_q <= status_d;
         depth_q  <= depth_d;
      end
   end

   assign bus.cmd_ready  = cmd_ready;
   assign bus.rsp_valid  = rsp_valid;
   assign bus.rsp_data   = data_q;
   assign bus.rsp_status = status_q;
   assign bus.depth      = depth_q;

   // The mirror counter must track the stack's own occupancy exactly
   a_empty_mirror: assert property (@(posedge clk) disable iff (rst)
      stack_empty == (depth_q == '0));
   a_full_mirror: assert property (@(posedge clk) disable iff (rst)
      stack_full == (depth_q == C_DEPTH_MAX));

endmodule

`default_nettype wire

// File: tb/tb_stack_sequencer.sv
// +-------------------------------------------------------------------+
// | tb_stack_sequencer : directed vector bench for stack_sequencer     |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module tb_stack_sequencer;
   import stack_pkg::*;

   localparam int DEPTH = 4;
   localparam int WIDTH = 32;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] din;
      logic [31:0] exp_data;
      logic [2:0]  exp_status;
      int          exp_lat;
      int          exp_depth;
      bit          chk_data;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;
   vec_t vecs[$];

   stack_sequencer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   stack_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] op, input logic [31:0] din,
                               input logic [31:0] ed, input logic [2:0] es,
                               input int el, input int edp, input bit cd);
      vec_t v;
      v.op = op; v.din = din; v.exp_data = ed; v.exp_status = es;
      v.exp_lat = el; v.exp_depth = edp; v.chk_data = cd;
      return v;
   endfunction

   // Drive one command, wait for its accept edge, then count cycles until rsp_valid
   task automatic issue(input logic [2:0] op, input logic [31:0] d,
                        output logic [31:0] rd, output logic [2:0] rs, output int lat);
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = bus.rsp_data;
      rs = bus.rsp_status;
   endtask

   task automatic release_rsp();
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      logic [31:0] rd;
      logic [2:0]  rs;
      int          lat;
      chk({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
      issue(v.op, v.din, rd, rs, lat);
      chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
      chk({tag, " status"}, 32'(rs), 32'(v.exp_status));
      if (v.chk_data) chk({tag, " data"}, rd, v.exp_data);
      release_rsp();
      chk({tag, " depth"}, 32'(bus.depth), 32'(v.exp_depth));
   endtask

   initial begin
      logic [31:0] rd, hold_d;
      logic [2:0]  rs, hold_s;
      int          lat;
      bit          stable, seen;

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_data  = '0;
      bus.rsp_ready = 1'b0;
      rst           = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset rsp_data", bus.rsp_data, 32'd0);
      chk("reset rsp_status", 32'(bus.rsp_status), 32'd0);
      chk("reset depth", 32'(bus.depth), 32'd0);
      rst = 1'b0;

      vecs.push_back(mk(CMD_PUSH, 32'd5,        32'd5,        RSP_OK,        2, 1, 1));
      vecs.push_back(mk(CMD_PUSH, 32'd7,        32'd7,        RSP_OK,        2, 2, 1));
      vecs.push_back(mk(CMD_ADD,  32'd0,        32'd12,       RSP_OK,        5, 1, 1));
      vecs.push_back(mk(CMD_PEEK, 32'd0,        32'd12,       RSP_OK,        1, 1, 1));
      vecs.push_back(mk(CMD_POP,  32'd0,        32'd12,       RSP_OK,        2, 0, 1));
      vecs.push_back(mk(CMD_PUSH, 32'h7FFFFFFF, 32'h7FFFFFFF, RSP_OK,        2, 1, 1));
      vecs.push_back(mk(CMD_PUSH, 32'd1,        32'd1,        RSP_OK,        2, 2, 1));
      vecs.push_back(mk(CMD_ADD,  32'd0,        32'h80000000, RSP_OVERFLOW,  5, 1, 1));
      vecs.push_back(mk(CMD_POP,  32'd0,        32'h80000000, RSP_OK,        2, 0, 1));
      vecs.push_back(mk(CMD_PUSH, 32'hFFFFFFFD, 32'hFFFFFFFD, RSP_OK,        2, 1, 1));
      vecs.push_back(mk(CMD_PUSH, 32'd4,        32'd4,        RSP_OK,        2, 2, 1));
      vecs.push_back(mk(CMD_MUL,  32'd0,        32'hFFFFFFF4, RSP_OK,        5, 1, 1));
      vecs.push_back(mk(CMD_POP,  32'd0,        32'hFFFFFFF4, RSP_OK,        2, 0, 1));
      vecs.push_back(mk(CMD_POP,  32'd0,        32'd0,        RSP_UNDERFLOW, 1, 0, 0));
      vecs.push_back(mk(CMD_PEEK, 32'd0,        32'd0,        RSP_UNDERFLOW, 1, 0, 0));
      vecs.push_back(mk(CMD_PUSH, 32'h00010000, 32'h00010000, RSP_OK,        2, 1, 1));
      vecs.push_back(mk(CMD_ADD,  32'd0,        32'd0,        RSP_UNDERFLOW, 1, 1, 0));
      vecs.push_back(mk(CMD_MUL,  32'd0,        32'd0,        RSP_UNDERFLOW, 1, 1, 0));
      vecs.push_back(mk(3'd5,     32'd0,        32'd0,        RSP_ILLEGAL,   1, 1, 0));
      vecs.push_back(mk(3'd7,     32'd0,        32'd0,        RSP_ILLEGAL,   1, 1, 0));
      vecs.push_back(mk(CMD_PUSH, 32'h00010000, 32'h00010000, RSP_OK,        2, 2, 1));
      vecs.push_back(mk(CMD_MUL,  32'd0,        32'd0,        RSP_OVERFLOW,  5, 1, 1));
      vecs.push_back(mk(CMD_PEEK, 32'd0,        32'd0,        RSP_OK,        1, 1, 1));
      vecs.push_back(mk(CMD_PUSH, 32'd3,        32'd3,        RSP_OK,        2, 2, 1));
      vecs.push_back(mk(CMD_PUSH, 32'd4,        32'd4,        RSP_OK,        2, 3, 1));
      vecs.push_back(mk(CMD_PUSH, 32'd6,        32'd6,        RSP_OK,        2, 4, 1));

      for (int i = 0; i < vecs.size(); i++)
         run_vec($sformatf("v%0d", i), vecs[i]);

      // Full stack: PUSH rejected, response held while rsp_ready stays low
      issue(CMD_PUSH, 32'd9, rd, rs, lat);
      chk("full latency", 32'(lat), 32'd1);
      chk("full status", 32'(rs), 32'(RSP_FULL));
      hold_d = rd;
      hold_s = rs;
      bus.cmd_op    = CMD_PEEK;
      bus.cmd_valid = 1'b1;
      stable = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (!bus.rsp_valid || bus.rsp_data !== hold_d ||
             bus.rsp_status !== hold_s || bus.cmd_ready) stable = 1'b0;
      end
      bus.cmd_valid = 1'b0;
      chk("hold stable", 32'(stable), 32'd1);
      release_rsp();
      chk("hold no extra rsp", 32'(bus.rsp_valid), 32'd0);
      chk("full depth", 32'(bus.depth), 32'd4);
      run_vec("full peek", mk(CMD_PEEK, 32'd0, 32'd6, RSP_OK, 1, 4, 1));
      run_vec("full pop",  mk(CMD_POP,  32'd0, 32'd6, RSP_OK, 2, 3, 1));
      run_vec("next pop",  mk(CMD_POP,  32'd0, 32'd4, RSP_OK, 2, 2, 1));

      // Reset while the ADD sequence sits in POP_A
      bus.cmd_op    = CMD_ADD;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst depth", 32'(bus.depth), 32'd0);
      chk("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
      seen = 1'b0;
      repeat (8) begin
         if (bus.rsp_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      chk("rst no response", 32'(seen), 32'd0);
      run_vec("rst peek", mk(CMD_PEEK, 32'd0, 32'd0, RSP_UNDERFLOW, 1, 0, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/stack_sequencer.md
# stack_sequencer

Command-level controller for the `stack` datapath. It accepts one stack command at a time over a valid/ready handshake, and sequences the stack's single-cycle opcodes into complete operations; ADD and MUL become a capture, pop, pop, push-result sequence. It returns one response per command with data and status. The block instantiates `stack` and is the only agent driving it.

## Interface
- `DEPTH`, 256, stack depth in entries; passed to `stack`.
- `WIDTH`, 32, data width in bits; passed to `stack`.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  3  0=PEEK, 1=PUSH, 2=POP, 3=ADD, 4=MUL, 5–7 illegal.
- `cmd_data`  in  WIDTH  signed operand; used by PUSH only.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_data`  out  WIDTH  signed result: peeked or popped value, or the ADD/MUL result.
- `rsp_status`  out  3  0=OK, 1=UNDERFLOW, 2=FULL, 3=OVERFLOW, 4=ILLEGAL.
- `depth`  out  $clog2(DEPTH)+1  current entry count.

## Operation
- **FSM states:** IDLE, EXEC_PUSH, EXEC_POP, CALC, POP_A, POP_B, PUSH_R, RESP.
- **IDLE:**
  - `cmd_ready`=1; stack opcode is 000, so `stack.output_data` shows the top entry.
  - On accept, latch the command and evaluate preconditions against `depth`:
    - PUSH needs `depth`<DEPTH; otherwise go to RESP with FULL.
    - POP and PEEK need `depth`≥1; otherwise UNDERFLOW.
    - ADD and MUL need `depth`≥2; otherwise UNDERFLOW.
    - Illegal op goes to RESP with ILLEGAL.
  - Errored commands never touch the stack.
- **PEEK:** capture `output_data` on the accept edge, then go to RESP with OK.
- **PUSH:** EXEC_PUSH drives opcode 110 with `input_data`=latched `cmd_data`; `depth`+1. `rsp_data` = pushed value.
- **POP:** EXEC_POP drives opcode 111 and captures `output_data` (the old top) on the same edge; `depth`−1.
- **ADD/MUL:**
  - CALC drives 100 or 101 and captures `output_data` and the `overflow` flag.
  - POP_A and POP_B each drive 111.
  - PUSH_R drives 110 with the captured result.
  - Net `depth`−1.
  - Result is truncated to WIDTH bits, as produced by `stack`.
  - If `overflow` was captured, status is OVERFLOW; the truncated result is still pushed and returned.
- **RESP:**
  - `rsp_valid`=1, with data and status held stable until `rsp_valid && rsp_ready`, then return to IDLE.
  - `cmd_ready`=0 in every state except IDLE.
- **Depth tracking:** `depth` is a mirror counter updated only on the cycles the block issues a push or pop. It must always equal the stack's internal count. Assert `stack.empty` == (`depth`==0) and `stack.full` == (`depth`==DEPTH).

## Timing
- Accept at clock edge E0.
- `rsp_valid` first rises in the cycle after:
  - E0 for PEEK and errored commands (latency 1);
  - E1 for PUSH and POP (latency 2);
  - E4 for ADD and MUL (latency 5).
- A response accepted at edge En makes `cmd_ready`=1 in the cycle after En. There is no same-cycle response/command overlap, so throughput is at most one command per latency+1 cycles.
- Exactly one stack opcode other than 000 is issued per cycle, and only in the EXEC/CALC/POP/PUSH states.
- **Reset values (cycle after `rst` is sampled high):**
  - `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_status`=0, `depth`=0.
  - State IDLE; the stack is cleared.
- **Reset mid-sequence:** any in-flight command and pending response are discarded; no response is produced.
- `cmd_valid` asserted while `cmd_ready`=0 is ignored. The producer must hold the command until accepted.

## Structure
- A shared package `stack_pkg` holds:
  - the cmd_op enum (PEEK..MUL);
  - the rsp_status enum;
  - the stack opcode constants (OP_ADD=3'b100, OP_MUL=3'b101, OP_PUSH=3'b110, OP_POP=3'b111, OP_NOP=3'b000);
  - the FSM state enum.
- One sub-module: `stack` (u_stack).
  - Its `rst_n` is driven by `~rst`.
  - Its `output_data`, `overflow`, `empty` and `full` are used only as described above.

## Test plan
- **Reset, PUSH 5, PUSH 7, ADD:**
  - PUSH responses are OK, 5 and OK, 7.
  - ADD response is 12, OK, arriving 5 cycles after accept.
  - `depth`=1; PEEK returns 12.
- **PUSH 0x7FFFFFFF, PUSH 1, ADD:** response 0x80000000 with OVERFLOW; `depth`=1.
- **PUSH −3, PUSH 4, MUL:** response −12, OK; then POP returns −12 with OK, and `depth`=0.
- **Empty stack:**
  - POP gives UNDERFLOW and PEEK gives UNDERFLOW; each responds in 1 cycle.
  - After one PUSH, ADD gives UNDERFLOW with `depth` still 1.
- **Full stack:**
  - Fill DEPTH entries (DEPTH=4 build), then PUSH 9 gives FULL; contents unchanged.
  - Then hold `rsp_ready`=0 for 10 cycles: the response stays stable and `cmd_ready` stays 0.
- **Reset during ADD:** assert `rst` in POP_A. No response follows; `depth`=0, `cmd_ready`=1, and PEEK gives UNDERFLOW.
